// File: rtl/sar_fine_ctrl.sv
// rtl/sar_fine_ctrl.sv - two-step ADC sequencer: latches the coarse code, then finds the fine bits by binary search
module sar_fine_ctrl #(
    parameter int COARSE_W   = 3,
    parameter int FINE_W     = 3,
    parameter int SAMPLE_CYC = 1,
    parameter int SETTLE     = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [COARSE_W-1:0]          coarse_i,
    input  logic                         cmp_i,
    output logic                         sample_o,
    output logic [COARSE_W+FINE_W-1:0]   dac_o,
    output logic [COARSE_W+FINE_W-1:0]   result_o,
    output logic                         eoc_o,
    output logic                         busy_o
);

    localparam int W       = COARSE_W + FINE_W;
    // One down-counter serves both the sample window and the per-bit settle time.
    localparam int CNT_MAX = (SAMPLE_CYC > SETTLE + 1) ? SAMPLE_CYC : SETTLE + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int KW      = (FINE_W > 1) ? $clog2(FINE_W) : 1;

    localparam logic [CW-1:0]     SAMPLE_LOAD = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0]     SETTLE_LOAD = CW'(SETTLE);
    localparam logic [KW-1:0]     K_TOP       = KW'(FINE_W - 1);
    localparam logic [FINE_W-1:0] FINE_TOP    = FINE_W'(1) << (FINE_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        COARSE,
        TEST,
        DONE
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [KW-1:0]         k_q;
    logic [COARSE_W-1:0]   coarse_q;
    logic [FINE_W-1:0]     fine_q;
    logic [FINE_W-1:0]     fine_d;
    logic [W-1:0]          result_q;
    logic                  sample_q;
    logic                  eoc_q;
    logic                  busy_q;

    // Trial update for the bit under test: drop it on a low comparator, then arm the next lower bit.
    always_comb begin
        fine_d = fine_q;
        if (!cmp_i) begin
            fine_d[k_q] = 1'b0;
        end
        if (k_q != '0) begin
            fine_d[k_q - KW'(1)] = 1'b1;
        end
    end

    // Sequencer FSM; every output is a register updated on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            coarse_q <= '0;
            fine_q   <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            eoc_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            eoc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q  <= SAMPLE;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= SAMPLE_LOAD;
                    end
                end
                SAMPLE: begin
                    if (cnt_q == '0) begin
                        state_q  <= COARSE;
                        sample_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                COARSE: begin
                    coarse_q <= coarse_i;
                    fine_q   <= FINE_TOP;
                    k_q      <= K_TOP;
                    cnt_q    <= SETTLE_LOAD;
                    state_q  <= TEST;
                end
                TEST: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        fine_q <= fine_d;
                        if (k_q != '0) begin
                            k_q   <= k_q - KW'(1);
                            cnt_q <= SETTLE_LOAD;
                        end else begin
                            state_q  <= DONE;
                            result_q <= {coarse_q, fine_d};
                            busy_q   <= 1'b0;
                            eoc_q    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // DAC returns to zero so IDLE drives nothing but the held result.
                    state_q  <= IDLE;
                    coarse_q <= '0;
                    fine_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sample_o = sample_q;
    assign dac_o    = {coarse_q, fine_q};
    assign result_o = result_q;
    assign eoc_o    = eoc_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_sar_fine_ctrl.sv
// tb/tb_sar_fine_ctrl.sv - directed scoreboard bench for sar_fine_ctrl
module tb_sar_fine_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [5:0] vin_r = '0;
    logic [2:0] coarse_r = '0;
    logic       sel = 1'b0;

    logic       cmp1, cmp2;
    logic       sample1, sample2, eoc1, eoc2, busy1, busy2;
    logic [5:0] dac1, dac2, res1, res2;

    logic       sample_o, eoc_o, busy_o;
    logic [5:0] dac_o, result_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    // Comparator model: keep the trial bit when the input is at or above the DAC code.
    assign cmp1 = (vin_r >= dac1);
    assign cmp2 = (vin_r >= dac2);

    assign sample_o = sel ? sample2 : sample1;
    assign eoc_o    = sel ? eoc2    : eoc1;
    assign busy_o   = sel ? busy2   : busy1;
    assign dac_o    = sel ? dac2    : dac1;
    assign result_o = sel ? res2    : res1;

    sar_fine_ctrl dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .coarse_i(coarse_r), .cmp_i(cmp1),
        .sample_o(sample1), .dac_o(dac1), .result_o(res1), .eoc_o(eoc1), .busy_o(busy1)
    );

    sar_fine_ctrl #(.COARSE_W(3), .FINE_W(3), .SAMPLE_CYC(2), .SETTLE(3)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .coarse_i(coarse_r), .cmp_i(cmp2),
        .sample_o(sample2), .dac_o(dac2), .result_o(res2), .eoc_o(eoc2), .busy_o(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference binary search: j<3 gives the j-th trial code, j==3 the final result.
    function automatic logic [5:0] model(input int vin, input int crs, input int j);
        int acc = crs * 8;
        int t;
        for (int b = 0; b < 3; b++) begin
            t = acc + (1 << (2 - b));
            if (b == j) return 6'(t);
            if (vin >= t) acc = t;
        end
        return 6'(acc);
    endfunction

    task automatic drive_start(input bit inst, input logic v);
        if (inst) start2 = v;
        else      start1 = v;
    endtask

    task automatic conv(input bit inst, input int vin, input int crs,
                        input int s, input int t, input bit glitch);
        int lat;
        logic [5:0] ed, er, fin;
        lat = s + 2 + 3 * (t + 1);
        fin = model(vin, crs, 3);
        sel = inst;
        vin_r = 6'(vin);
        coarse_r = 3'(crs);
        @(negedge clk);
        drive_start(inst, 1'b1);
        exp_q.push_back(fin);
        for (int c = 1; c <= lat + 3; c++) begin
            @(negedge clk);
            drive_start(inst, glitch && (c == 3 || c == 5));
            if (c <= s + 1)     ed = '0;
            else if (c < lat)   ed = model(vin, crs, (c - s - 2) / (t + 1));
            else if (c == lat)  ed = fin;
            else                ed = '0;
            chk("sample", sample_o, (c <= s));
            chk("busy", busy_o, (c < lat));
            chk("eoc", eoc_o, (c == lat));
            chk("dac", dac_o, ed);
            if (eoc_o) begin
                er = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk("result", result_o, er);
            end
            if (c > lat) chk("result_hold", result_o, fin);
        end
        drive_start(inst, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sample", sample1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_eoc", eoc1, 0);
        chk("rst_dac", dac1, 0);
        chk("rst_result", res1, 0);
        chk("rst_result2", res2, 0);
        rst_n = 1'b1;

        // Basic conversion, full-scale, zero-scale
        conv(0, 45, 5, 1, 1, 0);
        conv(0, 63, 7, 1, 1, 0);
        conv(0, 0, 0, 1, 1, 0);

        // Back-to-back with start held high for 40 cycles
        sel = 0;
        vin_r = 6'd18;
        coarse_r = 3'd2;
        @(negedge clk);
        start1 = 1'b1;
        exp_q.push_back(model(18, 2, 3));
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("b2b_eoc", eoc1, (c % 10 == 9));
            chk("b2b_busy", busy1, !(c % 10 == 9 || c % 10 == 0));
            if (eoc1) begin
                chk("b2b_result", res1, (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
            end
            if (c % 10 == 0 && c < 40) exp_q.push_back(model(18, 2, 3));
            if (c == 40) start1 = 1'b0;
        end
        chk("b2b_sb_empty", exp_q.size(), 0);

        // Extra start pulses during a conversion are ignored
        conv(0, 45, 5, 1, 1, 1);

        // Reset mid-conversion
        sel = 0;
        vin_r = 6'd18;
        coarse_r = 3'd2;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk("pre_rst_busy", busy1, 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sample", sample1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_eoc", eoc1, 0);
        chk("abort_dac", dac1, 0);
        chk("abort_result", res1, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_eoc", eoc1, 0);
            chk("post_rst_busy", busy1, 0);
        end
        conv(0, 45, 5, 1, 1, 0);

        // Longer sample window and settle time
        conv(1, 37, 4, 2, 3, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
